// File: rtl/vector_mem_responder.sv
// Memory-side responder: services one line request at a time as LANES sequential
// 32-bit beats on a narrow backing-memory port, assembling read lines.
module vector_mem_responder #(
   parameter int ADDR_W  = 14,
   parameter int LANES   = 8,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rden_RAM,
   input  logic                  wren_RAM,
   input  logic [ADDR_W-1:0]     address_RAM,
   input  logic [4*LANES-1:0]    byteena_RAM,
   input  logic [32*LANES-1:0]   writeData_RAM,
   output logic [32*LANES-1:0]   readData_RAM,
   output logic                  readvalid,
   output logic                  waitrequest,
   output logic [ADDR_W+2:0]     mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [3:0]            mem_byteena,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam int IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LANES - 1);
   localparam logic [IDX_W:0]   LAST_CAP  = (IDX_W + 1)'(LANES - 1);

   typedef enum logic [1:0] {IDLE, WR, RD, RDRAIN} state_t;

   state_t              state;
   logic [IDX_W-1:0]    beat;
   logic [IDX_W:0]      capCnt;
   logic [ADDR_W-1:0]   reqAddr;
   logic [4*LANES-1:0]  reqBe;
   logic [32*LANES-1:0] reqData;
   logic [32*LANES-1:0] lineBuf;
   logic [32*LANES-1:0] lineNext;
   logic                tagVld_p [MEM_LAT];
   logic [IDX_W-1:0]    tagIdx_p [MEM_LAT];
   logic                accept;
   logic                capture;
   logic                lastCap;
   logic [3:0]          beatBe;
   logic [31:0]         beatData;

   assign accept      = (state == IDLE) && (rden_RAM || wren_RAM);
   assign capture     = tagVld_p[MEM_LAT-1];
   assign lastCap     = capture && (capCnt == LAST_CAP);
   assign waitrequest = (state != IDLE);

   always_comb begin
      beatBe   = reqBe[{beat, 2'b00} +: 4];
      beatData = reqData[{beat, 5'b00000} +: 32];
      lineNext = lineBuf;
      lineNext[{tagIdx_p[MEM_LAT-1], 5'b00000} +: 32] = mem_rdata;
   end

   // Beat port is a pure decode of registered state, so reset forces it to zero at once
   always_comb begin
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_byteena = '0;
      mem_wdata   = '0;
      case (state)
         WR: begin
            mem_wr      = |beatBe;
            mem_addr    = {reqAddr, beat};
            mem_byteena = beatBe;
            mem_wdata   = beatData;
         end
         RD: begin
            mem_rd   = 1'b1;
            mem_addr = {reqAddr, beat};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         reqAddr <= address_RAM;
         reqBe   <= byteena_RAM;
         reqData <= writeData_RAM;
      end
   end

   // Tag pipe: each issued read beat emerges MEM_LAT cycles later with its lane index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LAT; i++) tagVld_p[i] <= 1'b0;
      end else begin
         tagVld_p[0] <= (state == RD);
         for (int i = 1; i < MEM_LAT; i++) tagVld_p[i] <= tagVld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tagIdx_p[0] <= beat;
      for (int i = 1; i < MEM_LAT; i++) tagIdx_p[i] <= tagIdx_p[i-1];
   end

   always_ff @(posedge clk) begin
      if (capture) lineBuf <= lineNext;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         beat         <= '0;
         capCnt       <= '0;
         readvalid    <= 1'b0;
         readData_RAM <= '0;
      end else begin
         readvalid <= 1'b0;
         if (capture) capCnt <= lastCap ? '0 : capCnt + 1'b1;
         case (state)
            IDLE: begin
               beat <= '0;
               if (wren_RAM)      state <= WR;
               else if (rden_RAM) state <= RD;
            end
            WR: begin
               if (beat == LAST_BEAT) begin
                  state <= IDLE;
                  beat  <= '0;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            RD: begin
               if (beat == LAST_BEAT) begin
                  state <= RDRAIN;
                  beat  <= '0;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            RDRAIN: begin
               // The final lane is merged straight into the output on its capture edge
               if (lastCap) begin
                  state        <= IDLE;
                  readvalid    <= 1'b1;
                  readData_RAM <= lineNext;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
Memory-side responder for the vector load/store unit's 256-bit line interface (rden_RAM/wren_RAM/address_RAM/byteena_RAM/writeData_RAM/readData_RAM). It accepts one line request at a time and services it as LANES sequential 32-bit beats on a narrow backing-memory port. For reads it assembles the line and returns it with a one-cycle readvalid strobe. It sits between the processor datapath and the 32-bit data memory bank, and asserts waitrequest back to the load/store unit while a request is in progress.

Parameters:
ADDR_W, 14, line address width (one address = one 256-bit line)
LANES, 8, 32-bit beats per line (line width = 32*LANES)
MEM_LAT, 1, backing-memory read latency in cycles (1..4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rden_RAM  input  1  line read request
wren_RAM  input  1  line write request
address_RAM  input  ADDR_W  line address
byteena_RAM  input  4*LANES  byte enables for the write line
writeData_RAM  input  32*LANES  write line data
readData_RAM  output  32*LANES  assembled read line
readvalid  output  1  one-cycle strobe: readData_RAM holds a completed read
waitrequest  output  1  high while a request is being serviced
mem_addr  output  ADDR_W+3  beat address {line address, beat index[2:0]}
mem_rd  output  1  backing read strobe
mem_wr  output  1  backing write strobe
mem_byteena  output  4  beat byte enables
mem_wdata  output  32  beat write data
mem_rdata  input  32  backing read data, valid MEM_LAT cycles after mem_rd

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; beat and capture counters=0; latency pipe cleared; all outputs 0, including readData_RAM.
- waitrequest = (state != IDLE). This signal is a registered-state decode, not a function of the inputs.
- Acceptance: in IDLE, a rising edge with rden_RAM or wren_RAM high latches the address, byteena, and writeData. The initiator need not hold them afterwards.
- If rden and wren are high together, the write wins and the read is dropped.
- FSM states: IDLE, WR, RD, RDRAIN.
- IDLE -> WR on wren; IDLE -> RD on rden alone.
- WR: one beat per cycle for beats i = 0..LANES-1.
  - mem_wr=1 only if byteena lane i != 0; otherwise the beat is skipped but still takes its cycle.
  - mem_byteena = byteena[4i+3:4i]; mem_wdata = data[32i+31:32i]; mem_addr = {addr, i}.
  - After beat LANES-1: -> IDLE.
  - waitrequest is high for exactly LANES cycles after the acceptance edge.
- RD: issues mem_rd=1 for beats 0..LANES-1 on consecutive cycles.
  - A MEM_LAT-deep valid/index pipe tags each beat.
  - mem_rdata is captured into lane i of the line buffer when its tag emerges.
  - After the last issue: -> RDRAIN.
- RDRAIN: waits for the last capture, then -> IDLE.
  - In the cycle state is IDLE again, readvalid=1 for exactly one cycle.
  - readData_RAM updates on the same edge and then holds until the next read completes. Writes never alter it.
  - readvalid and deasserted waitrequest appear LANES+MEM_LAT cycles after the acceptance edge.
- Back-to-back: a new request may be accepted in the same cycle readvalid is high or waitrequest is low.
- Requests seen while waitrequest=1 are ignored (not queued).
- mem_rd and mem_wr are never high in the same cycle. Outside WR/RD, the mem_* strobes are 0.
- mem_addr wraps naturally at 2^(ADDR_W+3); a line never straddles lines.
- Reset mid-operation: the transaction is aborted and no readvalid is produced.
  - Beats already written stay written (no rollback).
  - Read data returning after reset is discarded (pipe cleared).

Test Plan:
- Write line addr=0x0005, byteena=all 1s, data lanes 0x11111111..0x88888888 -> 8 consecutive mem_wr beats, mem_addr=0x28..0x2F, each with mem_byteena=0xF; waitrequest high exactly 8 cycles.
- Read addr=0x0005 with MEM_LAT=1 (model returns the stored words) -> mem_rd beats 0x28..0x2F; readvalid single pulse 9 cycles after acceptance; readData_RAM = the written line; repeat with MEM_LAT=3 -> pulse at 11 cycles.
- Partial write byteena=0x0000_00F0 (lane 1 only), data 0xDEADBEEF in lane 1 -> only beat 1 has mem_wr=1 with byteena 0xF; 8 cycles of waitrequest; a following read shows lane 1 = 0xDEADBEEF, other lanes unchanged.
- rden=wren=1 at addr 0x3FFF -> write performed at mem_addr 0x1FFF8..0x1FFFF, no mem_rd, no readvalid.
- Read issued, reset=0 asserted after beat 3 for one cycle -> all outputs 0 immediately, no readvalid; late mem_rdata ignored; the next read completes normally.
- Request held high during waitrequest, then read accepted the cycle readvalid pulses -> no duplicate transaction; second readvalid exactly LANES+MEM_LAT cycles later.
